// File: rtl/ef_pwm_db_pkg.sv
// Shared types and defaults for the PWM dead-band stage.
package ef_pwm_db_pkg;

  localparam int DT_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DT_RISE = 3'd1,
    ST_HIGH    = 3'd2,
    ST_DT_FALL = 3'd3,
    ST_LOW     = 3'd4,
    ST_FAULT   = 3'd5
  } state_t;

endpackage

// File: rtl/ef_pwm_db_cnt.sv
// Loadable dead-time down-counter; holds at zero once expired.
module ef_pwm_db_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/ef_pwm_deadband.sv
// Complementary gate-drive pair with programmable rise/fall dead time and sticky fault trip.
//
// state    | meaning
// IDLE     | disabled or just cleared, both drives off
// DT_RISE  | both off, waiting dt_rise before high side
// HIGH     | high side on
// DT_FALL  | both off, waiting dt_fall before low side
// LOW      | low side on
// FAULT    | tripped, both off until fault_clr
module ef_pwm_deadband
  import ef_pwm_db_pkg::*;
#(
  parameter int DT_W = DT_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            pwm_in,
  input  logic [DT_W-1:0] dt_rise,
  input  logic [DT_W-1:0] dt_fall,
  input  logic            pol_h,
  input  logic            pol_l,
  input  logic            fault_in,
  input  logic            fault_clr,
  output logic            out_h,
  output logic            out_l,
  output logic            dt_active,
  output logic            fault_flag
);

  state_t          state, state_nxt;
  logic            pwm_q;
  logic            drv_h, drv_l;
  logic            cnt_load;
  logic [DT_W-1:0] cnt_val;
  logic            cnt_zero;
  logic            go_rise, go_fall;

  // Counter is loaded with N-1 so the zero flag lands on the last dead cycle.
  ef_pwm_db_cnt #(.W(DT_W)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    go_rise   = 1'b0;
    go_fall   = 1'b0;
    if (fault_in) begin
      state_nxt = ST_FAULT;
    end else if (state == ST_FAULT) begin
      if (fault_clr) state_nxt = ST_IDLE;
    end else if (!en) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          go_rise = pwm_q;
          go_fall = !pwm_q;
        end
        ST_HIGH: go_fall = !pwm_q;
        ST_LOW:  go_rise = pwm_q;
        ST_DT_RISE: begin
          if (!pwm_q)        state_nxt = ST_LOW;
          else if (cnt_zero) state_nxt = ST_HIGH;
        end
        ST_DT_FALL: begin
          if (pwm_q)         state_nxt = ST_HIGH;
          else if (cnt_zero) state_nxt = ST_LOW;
        end
        default: state_nxt = ST_IDLE;
      endcase
      // Zero dead time swaps the drives directly without visiting a DT state.
      if (go_rise) begin
        if (dt_rise == '0) begin
          state_nxt = ST_HIGH;
        end else begin
          state_nxt = ST_DT_RISE;
          cnt_load  = 1'b1;
          cnt_val   = dt_rise - DT_W'(1);
        end
      end
      if (go_fall) begin
        if (dt_fall == '0) begin
          state_nxt = ST_LOW;
        end else begin
          state_nxt = ST_DT_FALL;
          cnt_load  = 1'b1;
          cnt_val   = dt_fall - DT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      pwm_q      <= 1'b0;
      drv_h      <= 1'b0;
      drv_l      <= 1'b0;
      dt_active  <= 1'b0;
      fault_flag <= 1'b0;
    end else begin
      state      <= state_nxt;
      pwm_q      <= pwm_in;
      drv_h      <= (state_nxt == ST_HIGH);
      drv_l      <= (state_nxt == ST_LOW);
      dt_active  <= (state_nxt == ST_DT_RISE) || (state_nxt == ST_DT_FALL);
      fault_flag <= (state_nxt == ST_FAULT);
    end
  end

  assign out_h = drv_h ^ pol_h;
  assign out_l = drv_l ^ pol_l;

endmodule

// File: tb/tb_ef_pwm_deadband.sv
// Scoreboard bench for ef_pwm_deadband: cycle model feeds a queue, plus directed latency checks.
module tb_ef_pwm_deadband;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       pwm_in;
  logic [7:0] dt_rise;
  logic [7:0] dt_fall;
  logic       pol_h;
  logic       pol_l;
  logic       fault_in;
  logic       fault_clr;
  logic       out_h;
  logic       out_l;
  logic       dt_active;
  logic       fault_flag;

  ef_pwm_deadband dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .pwm_in     (pwm_in),
    .dt_rise    (dt_rise),
    .dt_fall    (dt_fall),
    .pol_h      (pol_h),
    .pol_l      (pol_l),
    .fault_in   (fault_in),
    .fault_clr  (fault_clr),
    .out_h      (out_h),
    .out_l      (out_l),
    .dt_active  (dt_active),
    .fault_flag (fault_flag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int n_pop = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic h;
    logic l;
    logic dta;
    logic ff;
  } exp_t;

  exp_t sb_q[$];
  logic sb_on = 1'b0;

  localparam int M_IDL = 0, M_RISE = 1, M_HI = 2, M_FALL = 3, M_LO = 4, M_FLT = 5;
  int   m_mode = M_IDL;
  int   m_rem  = 0;
  logic m_q    = 1'b0;

  // Reference model: m_rem counts dead cycles still to go, leaving the DT state when it hits 0.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_mode = M_IDL;
      m_rem  = 0;
      m_q    = 1'b0;
    end else begin
      if (fault_in) begin
        m_mode = M_FLT;
      end else if (m_mode == M_FLT) begin
        if (fault_clr) m_mode = M_IDL;
      end else if (!en) begin
        m_mode = M_IDL;
      end else begin
        case (m_mode)
          M_IDL, M_HI, M_LO: begin
            if (m_q && m_mode != M_HI) begin
              if (dt_rise == 0) m_mode = M_HI;
              else begin m_mode = M_RISE; m_rem = int'(dt_rise); end
            end else if (!m_q && m_mode != M_LO) begin
              if (dt_fall == 0) m_mode = M_LO;
              else begin m_mode = M_FALL; m_rem = int'(dt_fall); end
            end
          end
          M_RISE: begin
            if (!m_q) m_mode = M_LO;
            else begin m_rem--; if (m_rem == 0) m_mode = M_HI; end
          end
          M_FALL: begin
            if (m_q) m_mode = M_HI;
            else begin m_rem--; if (m_rem == 0) m_mode = M_LO; end
          end
          default: m_mode = M_IDL;
        endcase
      end
      m_q = pwm_in;
      if (sb_on)
        sb_q.push_back('{h:   (m_mode == M_HI) ^ pol_h,
                         l:   (m_mode == M_LO) ^ pol_l,
                         dta: (m_mode == M_RISE) || (m_mode == M_FALL),
                         ff:  (m_mode == M_FLT)});
    end
  end

  initial forever begin
    exp_t e;
    @(posedge clk);
    #4;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_pop++;
      chk("sb_out_h", out_h, e.h);
      chk("sb_out_l", out_l, e.l);
      chk("sb_dt_active", dt_active, e.dta);
      chk("sb_fault_flag", fault_flag, e.ff);
      chk("no_overlap", (out_h ^ pol_h) & (out_l ^ pol_l), 0);
    end
  end

  // Drives pwm_in at the current negedge and records, per posedge index, when each drive turns on/off.
  task automatic track(input int ncyc, input logic pv, input int plen, input int chg_at,
                       input logic [7:0] chg_dt, output int h_on, output int h_off,
                       output int l_on, output int l_off, output int dtc);
    logic ph, pl, ch, cl;
    h_on = -1; h_off = -1; l_on = -1; l_off = -1; dtc = 0;
    ph = out_h ^ pol_h;
    pl = out_l ^ pol_l;
    pwm_in = pv;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      ch = out_h ^ pol_h;
      cl = out_l ^ pol_l;
      if (ch && !ph && h_on < 0) h_on = c;
      if (!ch && ph && h_off < 0) h_off = c;
      if (cl && !pl && l_on < 0) l_on = c;
      if (!cl && pl && l_off < 0) l_off = c;
      if (dt_active) dtc++;
      ph = ch;
      pl = cl;
      @(negedge clk);
      if (c + 1 == plen) pwm_in = ~pv;
      if (c == chg_at) dt_fall = chg_dt;
    end
  endtask

  int h_on, h_off, l_on, l_off, dtc;

  initial begin
    rst_n = 1'b0; en = 1'b0; pwm_in = 1'b0; dt_rise = 8'd3; dt_fall = 8'd5;
    pol_h = 1'b1; pol_l = 1'b0; fault_in = 1'b0; fault_clr = 1'b0;
    #3;
    chk("rst_out_h", out_h, 1);
    chk("rst_out_l", out_l, 0);
    chk("rst_dt_active", dt_active, 0);
    chk("rst_fault_flag", fault_flag, 0);
    repeat (2) @(negedge clk);
    pol_h = 1'b0;
    en    = 1'b1;
    sb_on = 1'b1;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // rise with dt_rise = 3, fall with dt_fall = 5
    track(12, 1'b1, 0, -1, 8'd0, h_on, h_off, l_on, l_off, dtc);
    chk("rise_l_off", l_off, 1);
    chk("rise_h_on", h_on, 4);
    chk("rise_dt_cycles", dtc, 3);
    track(12, 1'b0, 0, -1, 8'd0, h_on, h_off, l_on, l_off, dtc);
    chk("fall_h_off", h_off, 1);
    chk("fall_l_on", l_on, 6);
    chk("fall_dt_cycles", dtc, 5);

    // zero dead time: direct swap, toggling every 4 cycles
    dt_rise = 8'd0;
    dt_fall = 8'd0;
    for (int i = 0; i < 6; i++) begin
      track(4, ~pwm_in, 0, -1, 8'd0, h_on, h_off, l_on, l_off, dtc);
      chk("dt0_swap_h", pwm_in ? h_on : h_off, 1);
      chk("dt0_swap_l", pwm_in ? l_off : l_on, 1);
      chk("dt0_no_dt", dtc, 0);
    end
    repeat (4) @(negedge clk);

    // short pulse swallowed by dt_rise = 6
    dt_rise = 8'd6;
    pwm_in  = 1'b0;
    dt_fall = 8'd5;
    repeat (4) @(negedge clk);
    track(12, 1'b1, 2, -1, 8'd0, h_on, h_off, l_on, l_off, dtc);
    chk("swallow_h_on", h_on, -1);
    chk("swallow_l_off", l_off, 1);
    chk("swallow_l_on", l_on, 3);
    chk("swallow_dt_cycles", dtc, 2);

    // fault trip from HIGH
    dt_rise = 8'd3;
    pwm_in  = 1'b1;
    repeat (8) @(negedge clk);
    fault_in = 1'b1;
    @(posedge clk); #1;
    chk("flt_out_h", out_h, 0);
    chk("flt_out_l", out_l, 0);
    chk("flt_flag_set", fault_flag, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pwm_in = ~pwm_in;
    end
    @(negedge clk);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    chk("flt_clr_ignored", fault_flag, 1);
    fault_in = 1'b0;
    pwm_in   = 1'b1;
    repeat (3) @(negedge clk);
    chk("flt_sticky", fault_flag, 1);
    chk("flt_sticky_h", out_h, 0);
    fault_clr = 1'b1;
    @(posedge clk); #1;
    chk("flt_cleared", fault_flag, 0);
    @(negedge clk);
    fault_clr = 1'b0;
    track(10, 1'b1, 0, -1, 8'd0, h_on, h_off, l_on, l_off, dtc);
    chk("post_clr_h_on", h_on, 3);
    chk("post_clr_dt_cycles", dtc, 3);

    // dt_fall changed mid dead-time: current stays 5, next uses 2
    track(12, 1'b0, 0, 2, 8'd2, h_on, h_off, l_on, l_off, dtc);
    chk("dtchg_cur_l_on", l_on, 6);
    chk("dtchg_cur_dt_cycles", dtc, 5);
    pwm_in = 1'b1;
    repeat (8) @(negedge clk);
    track(12, 1'b0, 0, -1, 8'd0, h_on, h_off, l_on, l_off, dtc);
    chk("dtchg_next_l_on", l_on, 3);
    chk("dtchg_next_dt_cycles", dtc, 2);

    // en = 0 forces IDLE
    pwm_in = 1'b1;
    repeat (8) @(negedge clk);
    en = 1'b0;
    @(posedge clk); #1;
    chk("en0_out_h", out_h, 0);
    chk("en0_out_l", out_l, 0);
    @(negedge clk);
    en = 1'b1;
    repeat (8) @(negedge clk);

    // async reset mid-HIGH with pol_h = 1
    sb_on = 1'b0;
    pol_h = 1'b1;
    pol_l = 1'b0;
    #2;
    chk("high_pol_out_h", out_h, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_out_h", out_h, 1);
    chk("arst_out_l", out_l, 0);
    chk("arst_dt_active", dt_active, 0);
    chk("arst_fault_flag", fault_flag, 0);
    repeat (3) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    chk("sb_enough_pops", int'(n_pop > 100), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
